ft600_ro_arb: RTL and testbench
===============================

Name: ft600_ro_arb

Overview:
- Round-robin arbiter and burst scheduler for the FT600 Ro (FPGA-to-host) path.
- Shares the single 8-bit Ro character stream between two byte-stream requesters: ch0, the MesaBus readback, and ch1, the telemetry/debug stream.
- Its output drives the Ro character inputs of the FT600 FIFO FSM.
- Paces transfers with ft600_txe_l, bounds each burst and inserts turnaround gaps so neither requester can starve the other.

Parameters:
- MAX_BURST, 32: maximum bytes accepted per grant. Legal range 1..255.
- TURN_CYC, 2: idle cycles between grants. Legal range 1..15.

Ports:
- clk_ft  in  1  FT600 clock (66 or 100 MHz); the only clock.
- reset  in  1  Synchronous reset, active-high.
- ft600_txe_l  in  1  FT Ro path can accept data (active-low).
- ch0_vld  in  1  ch0 byte valid.
- ch0_d  in  8  ch0 byte.
- ch0_rdy  out  1  ch0 byte accepted this cycle.
- ch1_vld  in  1  ch1 byte valid.
- ch1_d  in  8  ch1 byte.
- ch1_rdy  out  1  ch1 byte accepted this cycle.
- arb_char_d  out  8  Byte to the FT600 FSM Ro character input.
- arb_char_rdy  out  1  One-cycle strobe qualifying arb_char_d.
- arb_gnt  out  2  One-hot current grant (bit0 = ch0); 00 when none.
- arb_busy  out  1  High whenever the FSM is not in IDLE.
- dbg_switch_cnt  out  16  Count of grants issued.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer favours ch0, burst counter 0, turn counter 0. Reset mid-burst drops any registered byte; arb_char_rdy is 0 on the next cycle.
- FSM states: IDLE, GRANT, TURN (plus TAG when the optional feature is compiled in).
- IDLE:
  - If ft600_txe_l==0 and any chN_vld==1, register a grant and enter GRANT on the next edge; arb_gnt updates with the state.
  - Both valid: grant the channel the pointer favours.
  - One valid: grant it regardless of the pointer.
  - dbg_switch_cnt increments on each grant and wraps FFFF->0000.
- GRANT:
  - chN_rdy is combinational: state==GRANT && arb_gnt[N] && ft600_txe_l==0. The non-granted rdy is always 0.
  - A transfer occurs on a cycle with vld && rdy. The next cycle arb_char_d = the byte and arb_char_rdy = 1 (latency 1). arb_char_rdy is 0 otherwise, and arb_char_d is 0 when not strobed.
  - The burst counter increments per transfer.
  - If ft600_txe_l==1: stall. No transfer, counter held, grant held, FSM stays in GRANT.
  - Leave to TURN when the counter reaches MAX_BURST (after the MAX_BURST-th transfer).
  - Also leave to TURN when the granted vld==0 on a cycle with ft600_txe_l==0 (source drained).
- TURN:
  - arb_gnt=00; hold for exactly TURN_CYC cycles, then go to IDLE.
  - The pointer is set to favour the channel not just served.
  - The burst counter clears on entry.
- Back-to-back: if the same channel alone is still valid, it is re-granted after TURN. A grant switch costs TURN_CYC+1 cycles with no transfer.
- Simultaneous events:
  - Requests arriving during TURN are ignored until IDLE.
  - ft600_txe_l rising on the same cycle as the last burst byte: that byte is not accepted, because rdy is already 0.
- arb_busy = (state != IDLE).

Optional Feature:
- Macro: FT600_ARB_TAG_EN.
- Defined:
  - A TAG state is inserted between IDLE and GRANT.
  - In TAG, when ft600_txe_l==0, the block emits one header byte: arb_char_d = 8'hA0 | channel index (A0 for ch0, A1 for ch1) with arb_char_rdy = 1, then enters GRANT. It waits in TAG while ft600_txe_l==1.
  - chN_rdy is 0 in TAG. The tag does not count toward MAX_BURST.
- Undefined: no TAG state; the first strobed byte of a grant is requester data.

Test Plan:
- Reset, then ch0 presents 5 bytes 01..05, ch1 idle, txe_l=0 -> one grant (arb_gnt=01), arb_char 01..05 on consecutive cycles at latency 1, then TURN for 2 cycles, dbg_switch_cnt=1.
- Both channels continuously valid, MAX_BURST=32 -> alternating bursts of exactly 32 bytes ch0, ch1, ch0, separated by 2 idle cycles; ch1_rdy never high during a ch0 grant.
- ch0 burst with txe_l held high for 10 cycles mid-burst at byte 7 -> no rdy and no strobe for those 10 cycles; resumes at byte 8; total still 32 before TURN.
- Assert reset during byte 12 of a ch1 burst -> next cycle all outputs 0 and pointer favours ch0; after release, simultaneous requests grant ch0 first.
- With FT600_ARB_TAG_EN: ch1 grant -> first strobe A1 then data bytes; txe_l high when entering TAG -> tag held until txe_l falls; burst still contains 32 data bytes.

Source files
------------

// File: rtl/ft600_ro_arb.sv
// rtl/ft600_ro_arb.sv - Round-robin Ro byte arbiter for the FT600 FIFO FSM (ch0 MesaBus, ch1 telemetry).
// Define FT600_ARB_TAG_EN to prefix each grant with a channel tag byte (8'hA0 | channel).
module ft600_ro_arb #(
  parameter int unsigned MAX_BURST = 32,
  parameter int unsigned TURN_CYC  = 2
) (
  input  logic        clk_ft,
  input  logic        reset,
  input  logic        ft600_txe_l,
  input  logic        ch0_vld,
  input  logic [7:0]  ch0_d,
  output logic        ch0_rdy,
  input  logic        ch1_vld,
  input  logic [7:0]  ch1_d,
  output logic        ch1_rdy,
  output logic [7:0]  arb_char_d,
  output logic        arb_char_rdy,
  output logic [1:0]  arb_gnt,
  output logic        arb_busy,
  output logic [15:0] dbg_switch_cnt
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);
  localparam logic [3:0] TURN_LAST  = 4'(TURN_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2,
    ST_TAG   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  gnt, gnt_nxt;
  logic        ptr, ptr_nxt;
  logic [7:0]  burst_cnt, burst_nxt;
  logic [3:0]  turn_cnt, turn_nxt;
  logic [7:0]  char_d, char_d_nxt;
  logic        char_rdy, char_rdy_nxt;
  logic [15:0] switch_cnt, switch_nxt;

  logic        pick;
  logic        gnt_vld;
  logic [7:0]  gnt_d;
  logic        leave;

  // ptr==0 favours ch0; a lone requester wins regardless of the pointer
  assign pick    = (ch0_vld && ch1_vld) ? ptr : ch1_vld;
  assign gnt_vld = gnt[1] ? ch1_vld : ch0_vld;
  assign gnt_d   = gnt[1] ? ch1_d : ch0_d;

  assign ch0_rdy = (state == ST_GRANT) && gnt[0] && !ft600_txe_l;
  assign ch1_rdy = (state == ST_GRANT) && gnt[1] && !ft600_txe_l;

  assign arb_char_d     = char_d;
  assign arb_char_rdy   = char_rdy;
  assign arb_gnt        = gnt;
  assign arb_busy       = (state != ST_IDLE);
  assign dbg_switch_cnt = switch_cnt;

  always_ff @(posedge clk_ft) begin
    if (reset) begin
      state      <= ST_IDLE;
      gnt        <= 2'b00;
      ptr        <= 1'b0;
      burst_cnt  <= 8'd0;
      turn_cnt   <= 4'd0;
      char_d     <= 8'd0;
      char_rdy   <= 1'b0;
      switch_cnt <= 16'd0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      ptr        <= ptr_nxt;
      burst_cnt  <= burst_nxt;
      turn_cnt   <= turn_nxt;
      char_d     <= char_d_nxt;
      char_rdy   <= char_rdy_nxt;
      switch_cnt <= switch_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    ptr_nxt      = ptr;
    burst_nxt    = burst_cnt;
    turn_nxt     = turn_cnt;
    char_d_nxt   = 8'd0;
    char_rdy_nxt = 1'b0;
    switch_nxt   = switch_cnt;
    leave        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!ft600_txe_l && (ch0_vld || ch1_vld)) begin
          gnt_nxt    = pick ? 2'b10 : 2'b01;
          switch_nxt = switch_cnt + 16'd1;
`ifdef FT600_ARB_TAG_EN
          state_nxt  = ST_TAG;
`else
          state_nxt  = ST_GRANT;
`endif
        end
      end

`ifdef FT600_ARB_TAG_EN
      ST_TAG: begin
        if (!ft600_txe_l) begin
          char_d_nxt   = 8'hA0 | {7'd0, gnt[1]};
          char_rdy_nxt = 1'b1;
          state_nxt    = ST_GRANT;
        end
      end
`endif

      ST_GRANT: begin
        // txe_l high is a pure stall: nothing moves
        if (!ft600_txe_l) begin
          if (gnt_vld) begin
            char_d_nxt   = gnt_d;
            char_rdy_nxt = 1'b1;
            burst_nxt    = burst_cnt + 8'd1;
            leave        = (burst_cnt + 8'd1 == BURST_LAST);
          end else begin
            leave = 1'b1;
          end
        end
        if (leave) begin
          state_nxt = ST_TURN;
          gnt_nxt   = 2'b00;
          ptr_nxt   = gnt[0];
          burst_nxt = 8'd0;
          turn_nxt  = 4'd0;
        end
      end

      ST_TURN: begin
        if (turn_cnt == TURN_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          turn_nxt = turn_cnt + 4'd1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ft600_ro_arb.sv
// tb/tb_ft600_ro_arb.sv - Scoreboard bench for ft600_ro_arb with randomized requesters and txe_l pacing.
module tb_ft600_ro_arb;

  localparam int MAX_BURST = 32;
  localparam int TURN_CYC  = 2;

  logic        clk_ft = 1'b0;
  logic        reset = 1'b0;
  logic        ft600_txe_l = 1'b1;
  logic        ch0_vld = 1'b0;
  logic [7:0]  ch0_d = 8'h00;
  logic        ch1_vld = 1'b0;
  logic [7:0]  ch1_d = 8'h00;
  logic        ch0_rdy, ch1_rdy;
  logic [7:0]  arb_char_d;
  logic        arb_char_rdy;
  logic [1:0]  arb_gnt;
  logic        arb_busy;
  logic [15:0] dbg_switch_cnt;

  ft600_ro_arb #(.MAX_BURST(MAX_BURST), .TURN_CYC(TURN_CYC)) dut (
    .clk_ft(clk_ft), .reset(reset), .ft600_txe_l(ft600_txe_l),
    .ch0_vld(ch0_vld), .ch0_d(ch0_d), .ch0_rdy(ch0_rdy),
    .ch1_vld(ch1_vld), .ch1_d(ch1_d), .ch1_rdy(ch1_rdy),
    .arb_char_d(arb_char_d), .arb_char_rdy(arb_char_rdy),
    .arb_gnt(arb_gnt), .arb_busy(arb_busy), .dbg_switch_cnt(dbg_switch_cnt)
  );

  always #5 clk_ft = ~clk_ft;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] src0[$];
  logic [7:0] src1[$];

  int gate0 = 0, gate1 = 0, txe_pct = 0;
  bit force_txe = 1'b0;
  int acc0_n = 0, acc1_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input bit c);
    return c ? 2'b10 : 2'b01;
  endfunction

  // Drive one cycle of requester/txe stimulus; accepted bytes become expectations
  task automatic cycle(input bit rst);
    @(negedge clk_ft);
    reset       = rst;
    ch0_vld     = (src0.size() > 0) && ($urandom_range(99) < gate0);
    ch0_d       = (src0.size() > 0) ? src0[0] : 8'h00;
    ch1_vld     = (src1.size() > 0) && ($urandom_range(99) < gate1);
    ch1_d       = (src1.size() > 0) ? src1[0] : 8'h00;
    ft600_txe_l = force_txe || ($urandom_range(99) < txe_pct);
    #1;
    check("rdy_legal", {30'd0, ch1_rdy & ~(arb_gnt[1] & ~ft600_txe_l),
                        ch0_rdy & ~(arb_gnt[0] & ~ft600_txe_l)}, 32'd0);
    if (ch0_vld && ch0_rdy) begin
      if (!rst) exp_q.push_back(src0[0]);
      void'(src0.pop_front());
      acc0_n++;
    end
    if (ch1_vld && ch1_rdy) begin
      if (!rst) exp_q.push_back(src1[0]);
      void'(src1.pop_front());
      acc1_n++;
    end
  endtask

  task automatic fill(input bit ch, input int n);
    for (int i = 0; i < n; i++) begin
      if (ch) src1.push_back(8'($urandom_range(255)));
      else    src0.push_back(8'($urandom_range(255)));
    end
  endtask

  task automatic drain(input int bound);
    int k = 0;
    gate0 = 100; gate1 = 100; txe_pct = 0; force_txe = 1'b0;
    while ((src0.size() > 0 || src1.size() > 0) && k < bound) begin
      cycle(1'b0);
      k++;
    end
    check("drain_done", src0.size() + src1.size(), 0);
    repeat (TURN_CYC + 4) cycle(1'b0);
  endtask

  // Reference model: grant timing/choice, burst limits, scoreboard of bytes
  int         z = 100;
  int         cnt = 0;
  int unsigned grants = 0;
  bit         favour = 1'b0, cur = 1'b0, tag_pend = 1'b0, armed = 1'b0;
  logic [1:0] prev_gnt = 2'b00;
  bit         tp, vg, drop, st, ech;
  logic [1:0] eg;

  always @(posedge clk_ft) begin
    #1;
    if (reset) begin
      check("reset_outputs", {4'd0, arb_char_rdy, arb_busy, arb_gnt, arb_char_d, dbg_switch_cnt}, 32'd0);
      armed = 1'b1; z = 100; cnt = 0; favour = 1'b0; tag_pend = 1'b0;
      grants = 0; prev_gnt = 2'b00;
    end else if (armed) begin
      if (arb_char_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL char_unexpected: got strobe 0x%0h, expected no strobe at %0t", arb_char_d, $time);
        end else begin
          check("char_d", {24'd0, arb_char_d}, {24'd0, exp_q.pop_front()});
        end
      end else begin
        check("char_d_idle", {24'd0, arb_char_d}, 32'd0);
      end

      if (prev_gnt != 2'b00) begin
        tp = tag_pend;
        if (arb_char_rdy) begin
          if (tp) tag_pend = 1'b0;
          else    cnt++;
        end
        vg   = cur ? ch1_vld : ch0_vld;
        drop = (cnt == MAX_BURST) || (!tp && !ft600_txe_l && !vg);
        eg   = drop ? 2'b00 : onehot(cur);
        check("gnt_hold", {30'd0, arb_gnt}, {30'd0, eg});
        if (drop) begin
          favour = !cur;
          z = 0;
        end
      end else begin
        if (z < 100) z++;
        st  = (z > TURN_CYC) && !ft600_txe_l && (ch0_vld || ch1_vld);
        ech = (ch0_vld && ch1_vld) ? favour : ch1_vld;
        eg  = st ? onehot(ech) : 2'b00;
        check("gnt_start", {30'd0, arb_gnt}, {30'd0, eg});
        if (st) begin
          cur = ech;
          cnt = 0;
          grants++;
`ifdef FT600_ARB_TAG_EN
          tag_pend = 1'b1;
          exp_q.push_back(8'hA0 | {7'd0, cur});
`endif
        end
      end
      check("busy", {31'd0, arb_busy}, {31'd0, (eg != 2'b00) || (z < TURN_CYC)});
      check("switch_cnt", {16'd0, dbg_switch_cnt}, {16'd0, grants[15:0]});
      prev_gnt = eg;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    bit stalled;
    int k;

    // ch0 alone, 5 bytes
    repeat (3) cycle(1'b1);
    for (int i = 1; i <= 5; i++) src0.push_back(8'(i));
    gate0 = 100; gate1 = 0; txe_pct = 0;
    repeat (20) cycle(1'b0);
    check("a_switch_cnt", {16'd0, dbg_switch_cnt}, 32'd1);
    check("a_src_empty", src0.size(), 0);

    // both requesters continuously valid
    fill(1'b0, 100);
    fill(1'b1, 100);
    drain(800);

    // txe_l stall for 10 cycles after the 7th byte of a ch0 burst
    fill(1'b0, 40);
    gate0 = 100; gate1 = 0; acc0_n = 0; stalled = 1'b0; k = 0;
    while (src0.size() > 0 && k < 400) begin
      if (acc0_n == 7 && !stalled) begin
        force_txe = 1'b1;
        repeat (10) cycle(1'b0);
        force_txe = 1'b0;
        stalled = 1'b1;
      end else begin
        cycle(1'b0);
      end
      k++;
    end
    check("c_stall_seen", {31'd0, stalled}, 32'd1);
    drain(200);

    // random valid gaps and txe_l pacing
    gate0 = 85; gate1 = 85; txe_pct = 15;
    for (int i = 0; i < 3000; i++) begin
      if (src0.size() == 0 && $urandom_range(7) == 0) fill(1'b0, $urandom_range(1, 80));
      if (src1.size() == 0 && $urandom_range(7) == 0) fill(1'b1, $urandom_range(1, 80));
      cycle(1'b0);
    end
    drain(1500);

    // reset on the 12th byte of a ch1 burst, then simultaneous requests
    fill(1'b1, 40);
    gate0 = 0; gate1 = 100; acc1_n = 0; k = 0;
    while (acc1_n < 11 && k < 200) begin
      cycle(1'b0);
      k++;
    end
    check("e_reach_byte11", acc1_n, 11);
    fill(1'b0, 20);
    gate0 = 100;
    cycle(1'b1);
    drain(400);

    repeat (10) cycle(1'b0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
